// File: rtl/fmc_spi_pkg.sv
// Shared types and helpers for the FMC150 common-SPI arbiter.
package fmc_spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    localparam int unsigned MAX_BITS = 32;
    localparam int unsigned LEN_W    = 6;

    // A zero or oversize length means a full 32-bit frame.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(MAX_BITS)) return LEN_W'(MAX_BITS);
        return len;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin picker: first valid requester above rr_ptr, wrapping.
module spi_rr_arbiter
    import fmc_spi_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand     = (32'(rr_ptr) + i) % NREQ;
            cand_idx = IDX_W'(cand);
            if (enable && !found && req_valid[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fmc_spi_arbiter.sv
// Arbitrates NREQ register-access requesters onto the single FMC150 SPI bus;
// one owner drives sclk/sdo at a time, each requester has its own csb and sdi.
module fmc_spi_arbiter
    import fmc_spi_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned CLKDIV   = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*32-1:0]    req_data,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [31:0]           rsp_data,
    output logic                  spi_sclk,
    output logic                  spi_sdo,
    output logic [NREQ-1:0]       spi_csb,
    input  logic [NREQ-1:0]       spi_sdi,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, rr_ptr_q;
    logic [LEN_W-1:0] len_q, bit_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      shreg_q, cap_q, rsp_data_q;
    logic [NREQ-1:0]  rsp_valid_q;
    logic             sclk_q;

    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             arb_en, accept, cnt_done, rise, fall, last_bit;
    logic [LEN_W-1:0] sel_len;
    logic [31:0]      sel_data;

    // Arbitration pauses for the rsp_valid cycle and while reset is held.
    assign arb_en = (state_q == IDLE) && !(|rsp_valid_q) && !RST;
    assign accept = |(req_valid & grant);

    spi_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_len  = norm_len(req_len[i*LEN_W +: LEN_W]);
                sel_data = req_data[i*32 +: 32];
            end
        end
    end

    always_comb begin
        case (state_q)
            SETUP:       cnt_done = (cnt_q == SETUP_LAST);
            SHIFT, GAP:  cnt_done = (cnt_q == DIV_LAST);
            HOLD:        cnt_done = (cnt_q == HOLD_LAST);
            default:     cnt_done = 1'b0;
        endcase
    end

    assign rise     = (state_q == SHIFT) && cnt_done && !sclk_q;
    assign fall     = (state_q == SHIFT) && cnt_done && sclk_q;
    assign last_bit = fall && (bit_cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = (CS_SETUP > 0) ? SETUP : SHIFT;
            SETUP:   if (cnt_done) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = (CS_HOLD > 0) ? HOLD : GAP;
            HOLD:    if (cnt_done) state_d = GAP;
            GAP:     if (cnt_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        spi_csb = '1;
        if (state_q == SETUP || state_q == SHIFT || state_q == HOLD) spi_csb[idx_q] = 1'b0;
        busy      = (state_q != IDLE);
        req_ready = grant;
    end

    // The shift register drains to zero after len shifts, so sdo idles low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q       <= '0;
            rr_ptr_q    <= IDX_W'(NREQ - 1);
            len_q       <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            sclk_q      <= 1'b0;
        end else begin
            cnt_q       <= (state_q == IDLE || cnt_done) ? '0 : cnt_q + CNT_W'(1);
            rsp_valid_q <= '0;
            if (accept) begin
                idx_q     <= grant_idx;
                rr_ptr_q  <= grant_idx;
                len_q     <= sel_len;
                shreg_q   <= sel_data << (LEN_W'(MAX_BITS) - sel_len);
                cap_q     <= '0;
                bit_cnt_q <= '0;
            end
            if (rise) begin
                sclk_q <= 1'b1;
                cap_q  <= {cap_q[30:0], spi_sdi[idx_q]};
            end
            if (fall) begin
                sclk_q    <= 1'b0;
                shreg_q   <= {shreg_q[30:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            end
            if (state_q == GAP && cnt_done) begin
                rsp_valid_q[idx_q] <= 1'b1;
                rsp_data_q         <= cap_q;
            end
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_sdo   = shreg_q[31];
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_fmc_spi_arbiter.sv
// Bench for fmc_spi_arbiter: transaction-level timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fmc_spi_arbiter;

    localparam int NREQ = 2;
    localparam int D    = 4;
    localparam int S    = 2;
    localparam int H    = 2;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*6-1:0]    req_len   = '0;
    logic [NREQ*32-1:0]   req_data  = '0;
    logic [NREQ-1:0]      req_ready, rsp_valid, spi_csb;
    logic [NREQ-1:0]      spi_sdi = '0;
    logic [31:0]          rsp_data;
    logic                 spi_sclk, spi_sdo, busy;

    logic [NREQ-1:0]      f_valid = '0;
    logic [NREQ*6-1:0]    f_len   = '0;
    logic [NREQ*32-1:0]   f_data  = '0;
    logic [NREQ-1:0]      f_ready, f_rsp_valid, f_csb;
    logic [NREQ-1:0]      f_sdi = '1;
    logic [31:0]          f_rsp_data;
    logic                 f_sclk, f_sdo, f_busy;

    fmc_spi_arbiter #(.NREQ(NREQ), .CLKDIV(D), .CS_SETUP(S), .CS_HOLD(H)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_len(req_len), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .spi_sclk(spi_sclk), .spi_sdo(spi_sdo), .spi_csb(spi_csb), .spi_sdi(spi_sdi),
        .busy(busy)
    );

    fmc_spi_arbiter #(.NREQ(NREQ), .CLKDIV(1), .CS_SETUP(0), .CS_HOLD(0)) dut_fast (
        .CLK(CLK), .RST(RST), .req_valid(f_valid), .req_ready(f_ready),
        .req_len(f_len), .req_data(f_data), .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
        .spi_sclk(f_sclk), .spi_sdo(f_sdo), .spi_csb(f_csb), .spi_sdi(f_sdi),
        .busy(f_busy)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction model state
    bit          m_active = 1'b0;
    int          m_A, m_idx, m_len, m_R;
    int          m_rr = NREQ - 1;
    logic [31:0] m_data, m_rsp_data = '0;

    // Device models and observations
    logic [31:0] dev_word [NREQ];
    int          dev_len  [NREQ];
    int          dev_cnt  [NREQ];
    int          rises;
    logic [31:0] sdo_word;
    int          csb_low  [NREQ];
    int          grant_log[$];
    logic        prev_sclk = 1'b0;
    logic        prev_sdo  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int norm(input int l);
        return (l == 0 || l > 32) ? 32 : l;
    endfunction

    // Per-cycle model and compare, sampled on the falling edge
    initial begin
        int              off, o, c, kbit;
        bit              found, end_txn;
        logic [NREQ-1:0] exp_csb, exp_ready, exp_rv;
        logic            exp_sclk, exp_sdo, exp_busy;
        logic [31:0]     w;
        forever begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (spi_csb[i]) dev_cnt[i] = 0;
                else if (prev_sclk && !spi_sclk) dev_cnt[i]++;
                w    = dev_word[i];
                kbit = dev_len[i] - 1 - dev_cnt[i];
                spi_sdi[i] = (kbit >= 0 && kbit < 32) ? w[kbit] : 1'b0;
            end
            if (!prev_sclk && spi_sclk) begin
                rises++;
                sdo_word = {sdo_word[30:0], spi_sdo};
            end
            for (int i = 0; i < NREQ; i++) if (!spi_csb[i]) csb_low[i]++;
            check("csb_one_hot", 32'($countones(~spi_csb) <= 1), 32'd1);
            if (spi_sdo !== prev_sdo) check("sdo_moves_with_sclk_low", 32'(spi_sclk), 32'd0);
            if (&spi_csb) check("sclk_quiet_when_deselected", 32'(spi_sclk), 32'd0);

            exp_csb = '1; exp_sclk = 1'b0; exp_sdo = 1'b0; exp_busy = 1'b0;
            exp_ready = '0; exp_rv = '0; end_txn = 1'b0; found = 1'b0;
            if (RST) begin
                m_active = 1'b0; m_rr = NREQ - 1; m_rsp_data = '0;
            end else if (m_active) begin
                off = cyc - m_A;
                if (off == m_R) begin
                    exp_rv[m_idx] = 1'b1;
                    m_rsp_data = (m_len == 32) ? dev_word[m_idx]
                                               : dev_word[m_idx] & ((32'd1 << m_len) - 32'd1);
                    end_txn = 1'b1;
                end else begin
                    exp_busy = 1'b1;
                    if (off <= S + 2*D*m_len + H) exp_csb[m_idx] = 1'b0;
                    if (off <= S) begin
                        exp_sdo = m_data[m_len-1];
                    end else if (off <= S + 2*D*m_len) begin
                        o        = off - S - 1;
                        exp_sclk = (o % (2*D)) >= D;
                        exp_sdo  = m_data[m_len - 1 - o/(2*D)];
                    end
                end
            end else begin
                c = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req_valid[(m_rr + k) % NREQ]) begin
                        found = 1'b1;
                        c = (m_rr + k) % NREQ;
                    end
                end
                if (found) begin
                    exp_ready[c] = 1'b1;
                    m_active = 1'b1; m_A = cyc; m_idx = c; m_rr = c;
                    m_len  = norm(int'(req_len[c*6 +: 6]));
                    m_data = req_data[c*32 +: 32];
                    m_R    = 1 + S + 2*D*m_len + H + D;
                    grant_log.push_back(c);
                    rises = 0; sdo_word = '0;
                    for (int i = 0; i < NREQ; i++) csb_low[i] = 0;
                end
            end
            check("csb", 32'(spi_csb), 32'(exp_csb));
            check("sclk", 32'(spi_sclk), 32'(exp_sclk));
            check("sdo", 32'(spi_sdo), 32'(exp_sdo));
            check("busy", 32'(busy), 32'(exp_busy));
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("rsp_data", rsp_data, m_rsp_data);
            if (end_txn) m_active = 1'b0;
            prev_sclk = spi_sclk;
            prev_sdo  = spi_sdo;
        end
    end

    task automatic start_req(input int idx, input int len, input logic [31:0] data, output int a);
        bit ok = 1'b0;
        a = -1;
        @(posedge CLK); #1;
        req_len[idx*6 +: 6]    = 6'(len);
        req_data[idx*32 +: 32] = data;
        req_valid[idx]         = 1'b1;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(negedge CLK); #1;
            if (req_ready[idx]) begin
                ok = 1'b1;
                a  = cyc;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int idx, output int r);
        bit ok = 1'b0;
        r = -1;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge CLK); #1;
            if (rsp_valid[idx]) begin
                ok = 1'b1;
                r  = cyc;
            end
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_grants(input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge CLK); #1;
            if (grant_log.size() >= n) ok = 1'b1;
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, r, hi, rc;
        for (int i = 0; i < NREQ; i++) begin
            dev_word[i] = '0; dev_len[i] = 32; dev_cnt[i] = 0; csb_low[i] = 0;
        end
        RST = 1'b0;
        #1 RST = 1'b1;

        // Contention from reset: both requesters valid while reset is held
        dev_word[0] = 32'hA; dev_word[1] = 32'h5; dev_len[0] = 4; dev_len[1] = 4;
        req_len  = {6'd4, 6'd4};
        req_data = {32'h6, 32'h9};
        req_valid = 2'b11;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_csb", 32'(spi_csb), 32'd3);
        check("reset_sclk", 32'(spi_sclk), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        grant_log.delete();
        RST = 1'b0;
        wait_grants(4);
        @(posedge CLK); #1;
        req_valid = '0;
        wait_rsp(1, r);
        check("rr_grant0", 32'(grant_log[0]), 32'd0);
        check("rr_grant1", 32'(grant_log[1]), 32'd1);
        check("rr_grant2", 32'(grant_log[2]), 32'd0);
        check("rr_grant3", 32'(grant_log[3]), 32'd1);
        check("rr_last_rsp", rsp_data, 32'h5);

        // Single write, sdi tied high
        dev_word[0] = 32'hFFFF_FFFF; dev_len[0] = 16;
        start_req(0, 16, 32'h0000_A5C3, a);
        wait_rsp(0, r);
        check("write_latency", 32'(r - a), 32'd137);
        check("write_rsp", rsp_data, 32'h0000_FFFF);
        check("write_sdo", sdo_word, 32'h0000_A5C3);
        check("write_rises", 32'(rises), 32'd16);
        check("write_csb_low", 32'(csb_low[0]), 32'd132);

        // Readback on requester 1
        dev_word[1] = 32'h005A_5A5A; dev_len[1] = 24;
        start_req(1, 24, 32'h0012_3456, a);
        wait_rsp(1, r);
        check("read_latency", 32'(r - a), 32'd201);
        check("read_rsp", rsp_data, 32'h005A_5A5A);
        check("read_csb0_idle", 32'(csb_low[0]), 32'd0);
        check("read_sdo", sdo_word, 32'h0012_3456);

        // Out-of-range lengths become full 32-bit frames
        dev_word[0] = 32'h1357_9BDF; dev_len[0] = 32;
        start_req(0, 0, 32'hDEAD_BEEF, a);
        wait_rsp(0, r);
        check("len0_latency", 32'(r - a), 32'd265);
        check("len0_rises", 32'(rises), 32'd32);
        check("len0_sdo", sdo_word, 32'hDEAD_BEEF);
        check("len0_rsp", rsp_data, 32'h1357_9BDF);
        start_req(0, 40, 32'hDEAD_BEEF, a);
        wait_rsp(0, r);
        check("len40_rises", 32'(rises), 32'd32);
        check("len40_sdo", sdo_word, 32'hDEAD_BEEF);

        // Reset during bit 7 of a frame on requester 1, then contention
        dev_word[1] = 32'hFFFF_FFFF; dev_len[1] = 16;
        start_req(1, 16, 32'h0000_A5C3, a);
        for (int k = 0; k < 500 && rises < 8; k++) begin
            @(negedge CLK); #1;
        end
        check("abort_reached_bit7", 32'(rises), 32'd8);
        RST = 1'b1;
        #1;
        check("abort_csb", 32'(spi_csb), 32'd3);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        dev_word[0] = 32'hA; dev_word[1] = 32'h5; dev_len[0] = 4; dev_len[1] = 4;
        req_len  = {6'd4, 6'd4};
        req_valid = 2'b11;
        repeat (4) @(posedge CLK);
        #1;
        grant_log.delete();
        RST = 1'b0;
        wait_grants(1);
        @(posedge CLK); #1;
        req_valid = '0;
        check("abort_first_winner", 32'(grant_log[0]), 32'd0);
        wait_rsp(0, r);
        check("abort_next_rsp", rsp_data, 32'hA);

        // Minimum timing instance: CLKDIV=1, no setup/hold, one bit
        @(posedge CLK); #1;
        f_len  = {6'd0, 6'd1};
        f_data = {32'd0, 32'd1};
        f_valid = 2'b01;
        a = -1;
        for (int k = 0; k < 50 && a < 0; k++) begin
            @(negedge CLK); #1;
            if (f_ready[0]) a = cyc;
        end
        if (a < 0) check("fast_accept_timeout", 32'd0, 32'd1);
        @(posedge CLK); #1;
        f_valid = '0;
        hi = 0; rc = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK); #1;
            if (f_sclk) hi++;
            if (f_rsp_valid[0] && rc < 0) rc = cyc;
        end
        check("fast_latency", 32'(rc - a), 32'd4);
        check("fast_sclk_high", 32'(hi), 32'd1);
        check("fast_rsp", f_rsp_data, 32'd1);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
